// File: rtl/if_fetch_stage_if.sv
// Fetch-stage pipeline interface: redirect/stall controls in,
// registered instruction bundle out toward IF/ID.
interface if_fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ir;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        valid;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    output ir,
    output npc,
    output pc,
    output valid
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    input  ir,
    input  npc,
    input  pc,
    input  valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, word-addressed instruction memory,
// registered ir/npc/valid bundle with branch flush and stall hold.
module if_fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  if_fetch_stage_if.master     fe,
  input  logic                 imem_we,
  input  logic [AW-1:0]        imem_waddr,
  input  logic [31:0]          imem_wdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        valid;
  } fetch_st_t;

  logic [31:0] r_mem [IMEM_DEPTH];
  fetch_st_t   r_st;
  fetch_st_t   w_nxt;
  logic [AW-1:0] w_idx;
  logic        w_oob;
  logic [31:0] w_rdata;
  logic [31:0] w_seq;
  logic [31:0] w_tgt;

  // Async read of the pre-edge array gives old data on read-during-write.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    w_idx   = r_st.pc[AW+1:2];
    w_oob   = |r_st.pc[31:AW+2];
    w_rdata = r_mem[w_idx];
    w_seq   = r_st.pc + 32'd4;
    w_tgt   = fe.branch_target & ~32'h3;
    w_nxt   = r_st;
    priority case (1'b1)
      fe.branch_taken: begin
        w_nxt.pc    = w_tgt;
        w_nxt.ir    = '0;
        w_nxt.npc   = '0;
        w_nxt.valid = 1'b0;
      end
      fe.stall: begin
        w_nxt = r_st;
      end
      default: begin
        w_nxt.pc    = w_seq;
        w_nxt.ir    = w_oob ? 32'h0 : w_rdata;
        w_nxt.npc   = w_seq;
        w_nxt.valid = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st.pc    <= RESET_PC;
      r_st.ir    <= '0;
      r_st.npc   <= '0;
      r_st.valid <= 1'b0;
    end else begin
      r_st <= w_nxt;
    end
  end

  assign fe.pc    = r_st.pc;
  assign fe.ir    = r_st.ir;
  assign fe.npc   = r_st.npc;
  assign fe.valid = r_st.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table for the fetch
// scenarios, then random traffic against a behavioural model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fe         (bus),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] tgt;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [31:0] ir;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        v;
  } vec_t;

  vec_t tv[$];

  int total;
  int bad;

  logic [31:0] mm [64];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_npc;
  logic        m_v;

  function automatic vec_t mk(
    input logic r, input logic s, input logic b,
    input logic [31:0] tgt, input logic we,
    input logic [5:0] wa, input logic [31:0] wd,
    input logic [31:0] ir, input logic [31:0] npc,
    input logic [31:0] pc, input logic v);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.tgt = tgt;
    x.we = we; x.wa = wa; x.wd = wd;
    x.ir = ir; x.npc = npc; x.pc = pc; x.v = v;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: spec rules applied to the pre-edge state.
  task automatic model_edge(input logic r, input logic s,
                            input logic b, input logic [31:0] tgt,
                            input logic we, input logic [5:0] wa,
                            input logic [31:0] wd);
    longint unsigned word;
    word = longint'(m_pc) / 4;
    if (r) begin
      m_pc = 32'h0; m_ir = 32'h0; m_npc = 32'h0; m_v = 1'b0;
    end else if (b) begin
      m_pc = {tgt[31:2], 2'b00};
      m_ir = 32'h0; m_npc = 32'h0; m_v = 1'b0;
    end else if (!s) begin
      m_ir  = (word < 64) ? mm[word] : 32'h0;
      m_npc = m_pc + 32'd4;
      m_pc  = m_pc + 32'd4;
      m_v   = 1'b1;
    end
    if (we) mm[wa] = wd;
  endtask

  task automatic apply(input logic r, input logic s, input logic b,
                       input logic [31:0] tgt, input logic we,
                       input logic [5:0] wa, input logic [31:0] wd);
    rst = r;
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = tgt;
    imem_we = we;
    imem_waddr = wa;
    imem_wdata = wd;
    @(posedge clk);
    model_edge(r, s, b, tgt, we, wa, wd);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    total = 0;
    bad = 0;
    m_pc = 0; m_ir = 0; m_npc = 0; m_v = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    imem_we = 1'b0;
    imem_waddr = 6'd0;
    imem_wdata = 32'h0;

    // Preload the whole memory while in reset.
    for (int i = 0; i < 64; i++) begin
      if (i < 4) w = 32'(17 * (i + 1));
      else if (i == 4) w = 32'hAA;
      else w = 32'hC0DE_0000 | 32'(i);
      apply(1, 0, 0, 0, 1, 6'(i), w);
    end
    apply(1, 0, 0, 0, 0, 0, 0);

    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_ir", bus.ir, 32'h0);
    chk("reset_npc", bus.npc, 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);

    //           r s b tgt            we wa wd        ir        npc     pc           v
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h11,   32'h4,  32'h4,       1));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h22,   32'h8,  32'h8,       1));
    tv.push_back(mk(0,1,0,32'h0,        0,0,0,        32'h22,   32'h8,  32'h8,       1));
    tv.push_back(mk(0,1,0,32'h0,        0,0,0,        32'h22,   32'h8,  32'h8,       1));
    tv.push_back(mk(0,1,0,32'h0,        0,0,0,        32'h22,   32'h8,  32'h8,       1));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h33,   32'hC,  32'hC,       1));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h44,   32'h10, 32'h10,      1));
    tv.push_back(mk(0,0,1,32'h12,       0,0,0,        32'h0,    32'h0,  32'h10,      0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'hAA,   32'h14, 32'h14,      1));
    tv.push_back(mk(0,1,1,32'h0,        0,0,0,        32'h0,    32'h0,  32'h0,       0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h11,   32'h4,  32'h4,       1));
    tv.push_back(mk(0,0,1,32'h100,      0,0,0,        32'h0,    32'h0,  32'h100,     0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h0,    32'h104,32'h104,     1));
    tv.push_back(mk(0,0,1,32'hFFFFFFFC, 0,0,0,        32'h0,    32'h0,  32'hFFFFFFFC,0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h0,    32'h0,  32'h0,       1));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h11,   32'h4,  32'h4,       1));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h22,   32'h8,  32'h8,       1));
    tv.push_back(mk(0,0,0,32'h0,        1,2,32'hBEEF, 32'h33,   32'hC,  32'hC,       1));
    tv.push_back(mk(0,0,1,32'h8,        0,0,0,        32'h0,    32'h0,  32'h8,       0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'hBEEF, 32'hC,  32'hC,       1));
    tv.push_back(mk(0,1,0,32'h0,        0,0,0,        32'hBEEF, 32'hC,  32'hC,       1));
    tv.push_back(mk(1,1,0,32'h0,        0,0,0,        32'h0,    32'h0,  32'h0,       0));
    tv.push_back(mk(0,0,0,32'h0,        0,0,0,        32'h11,   32'h4,  32'h4,       1));

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i].r, tv[i].s, tv[i].b, tv[i].tgt,
            tv[i].we, tv[i].wa, tv[i].wd);
      chk($sformatf("vec%0d_ir", i), bus.ir, tv[i].ir);
      chk($sformatf("vec%0d_npc", i), bus.npc, tv[i].npc);
      chk($sformatf("vec%0d_pc", i), bus.pc, tv[i].pc);
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(tv[i].v));
    end

    for (int n = 0; n < 2000; n++) begin
      logic        r, s, b, we;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 7) == 0);
      we  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) tgt = $urandom();
      else tgt = {22'h0, 8'($urandom_range(0, 79)), 2'($urandom())};
      apply(r, s, b, tgt, we, 6'($urandom()), $urandom());
      chk($sformatf("rnd%0d_ir", n), bus.ir, m_ir);
      chk($sformatf("rnd%0d_npc", n), bus.npc, m_npc);
      chk($sformatf("rnd%0d_pc", n), bus.pc, m_pc);
      chk($sformatf("rnd%0d_valid", n), 32'(bus.valid), 32'(m_v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 32-bit five-stage MIPS pipeline. It owns the program counter and a word-addressed instruction memory, and it produces the registered instruction word and next-PC that the IF/ID stage consumes. It also applies the pipeline controls that come back from later stages: hazard stall, branch redirect and flush. It is the producing end of the `ir`/`npc` interface into IF/ID.

## Interface
- `IMEM_DEPTH`, 64: instruction memory size in 32-bit words; power of two, 4..1024.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall` in 1: hazard stall from ID; holds PC and outputs.
- `branch_taken` in 1: redirect request from EX.
- `branch_target` in 32: redirect address; bits [1:0] are ignored (treated as 0).
- `imem_we` in 1: instruction-memory write enable (program load).
- `imem_waddr` in log2(IMEM_DEPTH): word index written when `imem_we`=1.
- `imem_wdata` in 32: word written.
- `ir` out 32: fetched instruction, registered.
- `npc` out 32: address of fetched instruction + 4, registered.
- `pc` out 32: current PC register, the next address to fetch.
- `valid` out 1: `ir`/`npc` hold a real fetched instruction; 0 means bubble.

## Operation
- Reset (`rst`=1 at an edge): `pc`=RESET_PC, `ir`=0, `npc`=0, `valid`=0. Reset overrides all other inputs. The instruction memory is not cleared.
- Priority at each edge, highest first: rst > branch_taken > stall > normal fetch.
- Normal fetch:
  - `ir` <= imem[`pc`[k+1:2]], where k = log2(IMEM_DEPTH).
  - `npc` <= `pc`+4.
  - `valid` <= 1.
  - `pc` <= `pc`+4.
- Branch (`branch_taken`=1, regardless of `stall`):
  - `pc` <= {`branch_target`[31:2],2'b00}.
  - `ir` <= 0 (NOP), `npc` <= 0, `valid` <= 0. This flushes the wrong-path instruction.
- Stall (`stall`=1, no branch): `pc`, `ir`, `npc` and `valid` all hold.
- Out-of-range fetch: if `pc`[31:k+2] != 0, then `ir` <= 0 and `valid` <= 1. There is no exception.
- PC arithmetic is modulo 2^32: `pc`=32'hFFFF_FFFC advances to 0 and `npc` becomes 0.
- Memory write: when `imem_we`=1 at an edge, imem[`imem_waddr`] <= `imem_wdata`. Writes are independent of `stall`, branch and `rst`.
- Read-during-write to the same word in the same edge: the fetch returns the old contents.

## Timing
- Fetch latency is 1 cycle: the word at `pc` during cycle n appears on `ir` after edge n.
- After `rst` is deasserted, the first edge fetches RESET_PC. `valid` first rises at that edge.
- Branch penalty: the edge that samples `branch_taken` produces one bubble (`valid`=0). The target instruction appears after the next edge.
- Stall asserted for N cycles freezes the outputs for exactly N edges. There is no skid and no lost or duplicated fetch.
- `branch_taken` together with `stall`: the branch wins, and the flush happens even while ID is stalled.
- `rst` asserted mid-stream: the next edge returns all outputs to their reset values. Any in-flight fetch is discarded.
- `pc` is a direct register output, with no combinational path from inputs to outputs.

## Test plan
- Reset/sequential fetch:
  - Stimulus: preload imem[0..3]=32'h11,22,33,44; hold `rst` 2 cycles, then release.
  - Required response: successive edges give `ir`=11,22,33,44, `npc`=4,8,12,16, `valid`=1; `pc` ends at 16.
- Stall:
  - Stimulus: raise `stall` for 3 cycles with `ir`=22, `npc`=8.
  - Required response: outputs and `pc`=8 hold for 3 edges; after release the next edge gives `ir`=33.
- Branch flush:
  - Stimulus: `branch_taken`=1 with target 32'h0000_0012 and imem[4]=32'hAA.
  - Required response: next edge gives `valid`=0, `ir`=0, `pc`=32'h10; the following edge gives `ir`=AA, `npc`=32'h14.
- Branch and stall together:
  - Stimulus: `stall`=1 and `branch_taken`=1 (target 0) in the same cycle.
  - Required response: `pc`=0, `valid`=0; stall does not block the redirect.
- Boundaries:
  - Stimulus: branch to 32'h0000_0100 with IMEM_DEPTH=64.
  - Required response: `ir`=0, `valid`=1.
  - Stimulus: branch to 32'hFFFF_FFFC.
  - Required response: `npc`=0 and `pc` wraps to 0.
- Read-during-write and mid-run reset:
  - Stimulus: write imem[2]=32'hBEEF on the same edge that fetches word 2.
  - Required response: old value returned; a refetch returns BEEF.
  - Stimulus: `rst` during stall.
  - Required response: all outputs clear next edge; imem retained.
